mem_access_unit: RTL and testbench

//  Memory stage directly upstream of Writeback: takes one load/store per handshake from EX, checks alignment,

---
 rtl/mem_access_unit_pkg.sv | 19 +
 rtl/mem_access_unit_lane_align.sv | 38 +++
 rtl/mem_access_unit.sv | 174 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared load/store funct3 codes and helpers for the memory access stage.
// Load-data masking by access size lives here so the datapath and lane logic agree.
package mem_access_unit_pkg;

  localparam logic [2:0] LS_B_OP  = 3'd0;
  localparam logic [2:0] LS_H_OP  = 3'd1;
  localparam logic [2:0] LS_W_OP  = 3'd2;
  localparam logic [2:0] LS_BU_OP = 3'd4;
  localparam logic [2:0] LS_HU_OP = 3'd5;

  function automatic logic [31:0] ld_mask(input logic [2:0] f3);
    case (f3)
      LS_B_OP, LS_BU_OP: return 32'h0000_00FF;
      LS_H_OP, LS_HU_OP: return 32'h0000_FFFF;
      default:           return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering for one access: byte enables, replicated store data,
// and a flag for misaligned addresses or funct3 codes that are illegal for the direction.
module lsu_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_store,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_bad
);

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    o_bad   = 1'b0;
    case (i_funct3)
      LS_B_OP, LS_BU_OP: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_bad   = i_store && (i_funct3 == LS_BU_OP);
      end
      LS_H_OP, LS_HU_OP: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_wdata[15:0]}};
        o_bad   = i_addr_lo[0] || (i_store && (i_funct3 == LS_HU_OP));
      end
      LS_W_OP: begin
        o_be  = 4'b1111;
        o_bad = |i_addr_lo;
      end
      default: o_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: accepts one load/store from EX, runs a req/ack bus cycle and hands
// right-justified load bytes plus status flags to Writeback as a one-cycle pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a new access from EX
//   ST_REQ  | bus request held, waiting for ack or timeout
//   ST_RESP | o_valid pulse to Writeback (also used for misaligned/illegal)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_err,
  output logic        o_valid,
  output logic [31:0] o_ldata,
  output logic [2:0]  o_funct3,
  output logic [4:0]  o_rd,
  output logic        o_is_load,
  output logic        o_misalign,
  output logic        o_buserr,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES);

  state_t            r_state;
  state_t            w_next;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [31:0]       r_addr;
  logic [1:0]        r_lo;
  logic [4:0]        r_rd;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_ldata;
  logic              r_misalign;
  logic              r_buserr;
  logic [TO_W-1:0]   r_cnt;

  logic              w_accept;
  logic              w_timeout;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_bad;
  logic [31:0]       w_ld_aligned;

  lsu_lane_align u_lane (
    .i_funct3  (i_funct3),
    .i_addr_lo (i_addr[1:0]),
    .i_store   (i_store),
    .i_wdata   (i_wdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_bad     (w_bad)
  );

  assign w_accept     = i_valid && (r_state == ST_IDLE);
  // Down-counter loaded on accept; the no-ack cycle that sees 1 is the last allowed one.
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && !i_dmem_ack && (r_cnt == TO_W'(1));
  assign w_ld_aligned = (i_dmem_rdata >> {r_lo, 3'b000}) & ld_mask(r_funct3);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_bad ? ST_RESP : ST_REQ;
      ST_REQ:  if (i_dmem_ack || w_timeout) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_store    <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= 32'd0;
      r_lo       <= 2'd0;
      r_rd       <= 5'd0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
      r_ldata    <= 32'd0;
      r_misalign <= 1'b0;
      r_buserr   <= 1'b0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_store    <= i_store;
      r_funct3   <= i_funct3;
      r_addr     <= {i_addr[31:2], 2'b00};
      r_lo       <= i_addr[1:0];
      r_rd       <= i_rd;
      r_be       <= w_be;
      r_wdata    <= w_wdata;
      r_ldata    <= 32'd0;
      r_misalign <= w_bad;
      r_buserr   <= 1'b0;
      r_cnt      <= TO_LOAD;
    end else if (r_state == ST_REQ) begin
      if (i_dmem_ack) begin
        r_buserr <= i_dmem_err;
        r_ldata  <= (i_dmem_err || r_store) ? 32'd0 : w_ld_aligned;
      end else if (w_timeout) begin
        r_buserr <= 1'b1;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    o_ready      = (r_state == ST_IDLE);
    o_busy       = (r_state != ST_IDLE);
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = 32'd0;
    o_dmem_wdata = 32'd0;
    o_dmem_be    = 4'd0;
    o_valid      = 1'b0;
    o_ldata      = 32'd0;
    o_funct3     = 3'd0;
    o_rd         = 5'd0;
    o_is_load    = 1'b0;
    o_misalign   = 1'b0;
    o_buserr     = 1'b0;
    case (r_state)
      ST_REQ: begin
        o_dmem_req   = 1'b1;
        o_dmem_we    = r_store;
        o_dmem_addr  = r_addr;
        o_dmem_wdata = r_wdata;
        o_dmem_be    = r_be;
      end
      ST_RESP: begin
        o_valid    = 1'b1;
        o_ldata    = r_ldata;
        o_funct3   = r_funct3;
        o_rd       = r_rd;
        o_is_load  = !r_store;
        o_misalign = r_misalign;
        o_buserr   = r_buserr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a per-cycle expectation model driven by the
// stimulus tasks, checked every negedge, plus literal checks on captured bus/result values.
module tb_mem_access_unit;

  localparam int TO = 4;
  localparam logic [2:0] B = 3'd0, H = 3'd1, W = 3'd2, BU = 3'd4, HU = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_store, i_dmem_ack, i_dmem_err;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata, i_dmem_rdata;
  logic [4:0]  i_rd;
  logic        o_ready, o_dmem_req, o_dmem_we, o_valid, o_is_load, o_misalign, o_buserr, o_busy;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_ldata;
  logic [3:0]  o_dmem_be;
  logic [2:0]  o_funct3;
  logic [4:0]  o_rd;

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready), .i_store(i_store), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata), .i_dmem_err(i_dmem_err),
    .o_valid(o_valid), .o_ldata(o_ldata), .o_funct3(o_funct3), .o_rd(o_rd),
    .o_is_load(o_is_load), .o_misalign(o_misalign), .o_buserr(o_buserr), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  // expected outputs for the current cycle
  logic        chk_en = 1'b0;
  logic        e_ready, e_req, e_we, e_valid, e_is_load, e_mis, e_berr;
  logic [31:0] e_addr, e_wdata, e_ldata;
  logic [3:0]  e_be;
  logic [2:0]  e_f3;
  logic [4:0]  e_rd;

  // captured DUT values for literal checks
  logic [31:0] cap_addr, cap_wdata, cap_ldata;
  logic [3:0]  cap_be;
  logic [2:0]  cap_f3;
  logic        cap_we, cap_mis, cap_berr;
  int          req_cycles, valid_cyc, acc_cyc, n_valid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic mdl_bad(input logic st, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      B:       return 1'b0;
      H:       return a[0];
      W:       return a[1:0] != 2'd0;
      BU, HU:  return st || (f3 == HU && a[0]);
      default: return 1'b1;
    endcase
  endfunction

  function automatic int mdl_bytes(input logic [2:0] f3);
    if (f3 == B || f3 == BU) return 1;
    if (f3 == H || f3 == HU) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] mdl_be(input logic [2:0] f3, input logic [31:0] a);
    int n = mdl_bytes(f3);
    if (n == 4) return 4'hF;
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] mdl_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n = mdl_bytes(f3);
    if (n == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] mdl_ldata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int n = mdl_bytes(f3);
    logic [31:0] s = rd >> (8 * a[1:0]);
    if (n == 4) return s;
    return s & ((32'd1 << (8 * n)) - 32'd1);
  endfunction

  task automatic set_idle();
    e_ready = 1'b1; e_req = 1'b0; e_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", o_ready, e_ready);
      chk("busy", o_busy, !e_ready);
      chk("req", o_dmem_req, e_req);
      chk("valid", o_valid, e_valid);
      if (e_req) begin
        chk("we", o_dmem_we, e_we);
        chk("addr", o_dmem_addr, e_addr);
        chk("wdata", o_dmem_wdata, e_wdata);
        chk("be", o_dmem_be, e_be);
      end
      if (e_valid) begin
        chk("ldata", o_ldata, e_ldata);
        chk("funct3", o_funct3, e_f3);
        chk("rd", o_rd, e_rd);
        chk("is_load", o_is_load, e_is_load);
        chk("misalign", o_misalign, e_mis);
        chk("buserr", o_buserr, e_berr);
      end else begin
        chk("result_quiet", {o_ldata[30:0], o_is_load}, 32'd0);
        chk("flags_quiet", {o_misalign, o_buserr, o_ldata[31]}, 32'd0);
      end
    end
    if (o_dmem_req) begin
      cap_addr = o_dmem_addr; cap_wdata = o_dmem_wdata; cap_be = o_dmem_be; cap_we = o_dmem_we;
      req_cycles++;
    end
    if (o_valid) begin
      cap_ldata = o_ldata; cap_f3 = o_funct3; cap_mis = o_misalign; cap_berr = o_buserr;
      valid_cyc = cyc; n_valid++;
    end
  end

  // ack_dly: REQ cycle index carrying ack (-1 = never ack); hold: present i_valid during RESP
  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] rd, input int ack_dly,
                           input logic [31:0] rdata, input logic err, input logic hold);
    logic        bad, berr, fin;
    logic [31:0] res;
    int          n;
    bad = mdl_bad(st, f3, a);
    res = 32'd0; berr = 1'b0;
    i_valid = 1'b1; i_store = st; i_funct3 = f3; i_addr = a; i_wdata = d; i_rd = rd;
    set_idle();
    req_cycles = 0;
    @(posedge clk); acc_cyc = cyc; #1;
    i_valid = 1'b0; i_store = ~st; i_funct3 = 3'd7; i_addr = 32'hFFFF_FFFF; i_wdata = 32'h5555_5555; i_rd = ~rd;
    e_f3 = f3; e_rd = rd; e_is_load = !st;
    if (!bad) begin
      e_ready = 1'b0; e_req = 1'b1; e_valid = 1'b0; e_we = st;
      e_addr = {a[31:2], 2'b00}; e_wdata = mdl_wdata(f3, d); e_be = mdl_be(f3, a);
      fin = 1'b0; n = 0;
      while (!fin && n < 20) begin
        i_dmem_ack   = (n == ack_dly);
        i_dmem_rdata = i_dmem_ack ? rdata : 32'hA5A5_5A5A;
        i_dmem_err   = i_dmem_ack ? err : 1'b1;
        @(posedge clk); #1;
        n++;
        if (i_dmem_ack) begin
          fin = 1'b1; berr = err; res = (err || st) ? 32'd0 : mdl_ldata(f3, a, rdata);
        end else if (n == TO) begin
          fin = 1'b1; berr = 1'b1; res = 32'd0;
        end
      end
      if (!fin) chk("req_cycle_bound", 32'(n), 32'd0);
      i_dmem_ack = 1'b0; i_dmem_err = 1'b0;
    end
    e_ready = 1'b0; e_req = 1'b0; e_valid = 1'b1; e_ldata = res; e_mis = bad; e_berr = berr;
    if (hold) begin
      i_valid = 1'b1; i_store = 1'b0; i_funct3 = W; i_addr = 32'h3001;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    set_idle();
  endtask

  initial begin
    #200000;
    n_errs++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_store = 1'b0; i_funct3 = 3'd0; i_addr = 32'd0; i_wdata = 32'd0;
    i_rd = 5'd0; i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0; i_dmem_err = 1'b0;
    n_valid = 0; req_cycles = 0;
    set_idle();
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_access(1'b0, W, 32'h1000, 32'd0, 5'd5, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("lw_be", cap_be, 4'hF);
    chk("lw_ldata", cap_ldata, 32'hDEAD_BEEF);
    chk("lw_latency", 32'(valid_cyc - acc_cyc), 32'd2);

    do_access(1'b0, B, 32'h1003, 32'd0, 5'd6, 2, 32'h80AA_BBCC, 1'b0, 1'b0);
    chk("lb_addr", cap_addr, 32'h1000);
    chk("lb_be", cap_be, 4'h8);
    chk("lb_ldata", cap_ldata, 32'h0000_0080);
    chk("lb_funct3", cap_f3, 3'd0);

    do_access(1'b1, H, 32'h2002, 32'h1234_ABCD, 5'd7, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("sh_we", cap_we, 1'b1);
    chk("sh_be", cap_be, 4'hC);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_ldata", cap_ldata, 32'd0);

    do_access(1'b0, W, 32'h3001, 32'd0, 5'd8, 0, 32'd0, 1'b0, 1'b0);
    chk("lw_mis_noreq", 32'(req_cycles), 32'd0);
    chk("lw_mis_flag", cap_mis, 1'b1);
    chk("lw_mis_latency", 32'(valid_cyc - acc_cyc), 32'd1);

    do_access(1'b1, BU, 32'h4000, 32'h11, 5'd9, 0, 32'd0, 1'b0, 1'b0);
    chk("sb_f3_4_noreq", 32'(req_cycles), 32'd0);
    chk("sb_f3_4_mis", cap_mis, 1'b1);
    do_access(1'b0, 3'd3, 32'h4000, 32'd0, 5'd10, 0, 32'd0, 1'b0, 1'b0);
    chk("f3_3_mis", cap_mis, 1'b1);

    do_access(1'b0, W, 32'h5000, 32'd0, 5'd11, -1, 32'd0, 1'b0, 1'b0);
    chk("to_req_cycles", 32'(req_cycles), 32'd4);
    chk("to_buserr", cap_berr, 1'b1);

    do_access(1'b0, H, 32'h6002, 32'd0, 5'd12, 1, 32'h1234_5678, 1'b1, 1'b0);
    chk("err_buserr", cap_berr, 1'b1);
    chk("err_ldata", cap_ldata, 32'd0);

    do_access(1'b0, HU, 32'h7002, 32'd0, 5'd13, 0, 32'hFEDC_1234, 1'b0, 1'b0);
    chk("lhu_ldata", cap_ldata, 32'h0000_FEDC);
    do_access(1'b0, BU, 32'h7001, 32'd0, 5'd14, 3, 32'h1122_3344, 1'b0, 1'b0);
    chk("lbu_ldata", cap_ldata, 32'h0000_0033);
    do_access(1'b0, H, 32'h7001, 32'd0, 5'd15, 0, 32'd0, 1'b0, 1'b0);
    chk("lh_odd_mis", cap_mis, 1'b1);
    do_access(1'b1, B, 32'h7002, 32'h0000_00A7, 5'd16, 0, 32'd0, 1'b0, 1'b0);
    chk("sb_wdata", cap_wdata, 32'hA7A7_A7A7);
    chk("sb_be", cap_be, 4'h4);

    // no accept during RESP; idle ack must be ignored
    do_access(1'b0, W, 32'h7100, 32'd0, 5'd17, 0, 32'h0BAD_F00D, 1'b0, 1'b1);
    i_dmem_ack = 1'b1; i_dmem_err = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_dmem_ack = 1'b0; i_dmem_err = 1'b0;

    // reset mid-REQ aborts the access without a result
    i_valid = 1'b1; i_store = 1'b0; i_funct3 = W; i_addr = 32'h8000; i_rd = 5'd18;
    @(posedge clk); #1;
    i_valid = 1'b0;
    e_ready = 1'b0; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h8000; e_wdata = 32'h5555_5555;
    e_be = 4'hF; e_valid = 1'b0;
    i_wdata = 32'h5555_5555;
    @(posedge clk); #1;
    rst = 1'b1;
    n_valid = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle();
    chk("rst_req_dropped", o_dmem_req, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    @(posedge clk); #1;
    chk("rst_no_valid", 32'(n_valid), 32'd0);
    do_access(1'b0, W, 32'h8004, 32'd0, 5'd19, 0, 32'hCAFE_0001, 1'b0, 1'b0);
    chk("post_rst_ldata", cap_ldata, 32'hCAFE_0001);
    chk("post_rst_valid_count", 32'(n_valid), 32'd1);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
